// File: rtl/adder_pkg.sv
// Shared constants and result types for the registered adder family.
package adder_pkg;
  localparam int DEFAULT_ADDER_WIDTH = 4;

  // Result layout at the default width: the carry is the MSB, so {carry, sum} == a + b.
  typedef struct packed {
    logic                           carry;
    logic [DEFAULT_ADDER_WIDTH-1:0] sum;
  } adder_res_t;
endpackage

// File: rtl/fa_cell.sv
// One-bit full adder: a single link of the ripple-carry chain.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);
endmodule

// File: rtl/param_half_adder.sv
// Registered unsigned a + b with carry-out and a one-cycle valid qualifier.
module param_half_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);
  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
  } res_t;

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  res_t             nxt, res_q;
  logic [0:0]       vld_pipe;

  // No carry-in: the chain starts from a constant zero.
  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_cell u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign nxt = '{carry: c[WIDTH], sum: s};

  // Result holds when not qualified; reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q    <= '0;
      vld_pipe <= '0;
    end else begin
      if (in_valid) res_q <= nxt;
      vld_pipe[0] <= in_valid;
    end
  end

  assign sum       = res_q.sum;
  assign carry     = res_q.carry;
  assign out_valid = vld_pipe[0];
endmodule

// File: tb/tb_param_half_adder.sv
// Scoreboard bench driving WIDTH = 4, 1 and 8 instances in lockstep.
module tb_param_half_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       c4, c1, c8, ov4, ov1, ov8;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] q4[$];
  logic [1:0] q1[$];
  logic [8:0] q8[$];
  logic [4:0] last4;
  logic [1:0] last1;
  logic [8:0] last8;

  always #5 clk = ~clk;

  param_half_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4),
    .sum(sum4), .carry(c4), .out_valid(ov4));
  param_half_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
    .sum(sum1), .carry(c1), .out_valid(ov1));
  param_half_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
    .sum(sum8), .carry(c8), .out_valid(ov8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flush_model();
    q4.delete(); q1.delete(); q8.delete();
    last4 = '0; last1 = '0; last8 = '0;
  endtask

  // Hold reset for n edges with live, qualified operands; they must be discarded.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b1;
      a4 = 4'hF; b4 = 4'hF; a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      @(posedge clk); #1;
      chk("rst_sum4", sum4, 0); chk("rst_c4", c4, 0); chk("rst_ov4", ov4, 0);
      chk("rst_sum1", sum1, 0); chk("rst_ov1", ov1, 0);
      chk("rst_sum8", sum8, 0); chk("rst_ov8", ov8, 0);
    end
    flush_model();
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic step(input logic v, input logic [3:0] x4, input logic [3:0] y4,
                      input logic x1, input logic y1,
                      input logic [7:0] x8, input logic [7:0] y8);
    logic [4:0] e4;
    logic [1:0] e1;
    logic [8:0] e8;
    @(negedge clk);
    in_valid = v; a4 = x4; b4 = y4; a1 = x1; b1 = y1; a8 = x8; b8 = y8;
    if (v) begin
      q4.push_back({1'b0, x4} + {1'b0, y4});
      q1.push_back({1'b0, x1} + {1'b0, y1});
      q8.push_back({1'b0, x8} + {1'b0, y8});
    end
    @(posedge clk); #1;
    chk("ov4", ov4, v); chk("ov1", ov1, v); chk("ov8", ov8, v);
    if (ov4) begin
      if (q4.size() == 0) chk("sb4_empty", 1, 0);
      else begin e4 = q4.pop_front(); last4 = e4; end
    end
    if (ov1) begin
      if (q1.size() == 0) chk("sb1_empty", 1, 0);
      else begin e1 = q1.pop_front(); last1 = e1; end
    end
    if (ov8) begin
      if (q8.size() == 0) chk("sb8_empty", 1, 0);
      else begin e8 = q8.pop_front(); last8 = e8; end
    end
    // With in_valid low the registers must still show the last accepted result.
    chk("res4", {c4, sum4}, last4);
    chk("res1", {c1, sum1}, last1);
    chk("res8", {c8, sum8}, last8);
  endtask

  initial begin
    flush_model();
    do_reset(2);

    // Basic and carry-boundary vectors; W1 walks its truth table alongside.
    step(1, 4'b0001, 4'b0001, 0, 0, 8'hFF, 8'h01);
    step(1, 4'b0111, 4'b0011, 0, 1, 8'h7F, 8'h01);
    step(1, 4'b1111, 4'b0001, 1, 0, 8'h80, 8'h80);
    step(1, 4'b1111, 4'b0010, 1, 1, 8'hFF, 8'hFF);
    step(1, 4'b0001, 4'b1111, 1, 1, 8'h00, 8'h00);
    step(1, 4'b0110, 4'b1111, 0, 1, 8'h12, 8'h34);
    step(1, 4'b1111, 4'b1111, 1, 0, 8'hFE, 8'h01);

    // Valid gating: operands change while unqualified and must be ignored.
    step(1, 4'b0011, 4'b0000, 1, 0, 8'h10, 8'h20);
    step(0, 4'b0100, 4'b0001, 1, 1, 8'hFF, 8'hFF);
    chk("gate_sum4", sum4, 4'b0011);
    chk("gate_c4", c4, 1'b0);
    step(0, 4'b1111, 4'b1111, 0, 0, 8'h01, 8'h01);

    // Pseudo-random burst with interleaved bubbles.
    for (int i = 0; i < 40; i++)
      step(logic'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));

    // Reset mid-stream drops the in-flight result; first output follows first qualified input.
    step(1, 4'b0101, 4'b0101, 1, 1, 8'hAA, 8'h55);
    do_reset(1);
    step(0, 4'b1111, 4'b1111, 1, 1, 8'hFF, 8'hFF);
    step(1, 4'b1000, 4'b1000, 1, 1, 8'hC0, 8'h40);
    chk("post_rst_sum4", sum4, 4'b0000);
    chk("post_rst_c4", c4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
